// File: rtl/issue_sched_pkg.sv
// Shared types and helpers for the issue scheduler: per-slot state encoding and
// a round-robin first-set search usable at any buffer size up to MAX_BS.
package issue_sched_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    WAIT   = 2'd1,
    SEL    = 2'd2,
    ISSUED = 2'd3
  } slot_state_t;

  localparam int MAX_BS = 64;
  localparam int MAX_IW = 6;

  // Returns {found, idx}: first set bit of mask scanning ptr, ptr+1, ... modulo n (n a power of 2).
  function automatic logic [MAX_IW:0] rr_pick(input logic [MAX_BS-1:0] mask,
                                              input logic [MAX_IW-1:0] ptr,
                                              input logic [MAX_IW:0]   n);
    logic [MAX_IW:0]   res;
    logic [MAX_IW-1:0] idx;
    logic [MAX_IW-1:0] wrap;
    res  = {(MAX_IW+1){1'b0}};
    wrap = n[MAX_IW-1:0] - {{(MAX_IW-1){1'b0}}, 1'b1};
    for (int k = MAX_BS - 1; k >= 0; k--) begin
      idx = (ptr + k[MAX_IW-1:0]) & wrap;
      if ((k < int'(n)) && mask[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/issue_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first candidate at or after ptr,
// wrapping modulo BS, and reports it both one-hot and as an index.
module rr_arbiter
  import issue_sched_pkg::*;
#(
  parameter int BS = 16,
  localparam int IW = $clog2(BS)
) (
  input  logic [BS-1:0] mask,
  input  logic [IW-1:0] ptr,
  output logic [BS-1:0] grant,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [MAX_BS-1:0] mask_ext_s;
  logic [MAX_IW-1:0] ptr_ext_s;
  logic [MAX_IW:0]   pick_s;
  logic              unused_s;

  // Widen to the helper's fixed width, search, and decode the winner
  always_comb begin
    mask_ext_s          = {MAX_BS{1'b0}};
    mask_ext_s[BS-1:0]  = mask;
    ptr_ext_s           = {MAX_IW{1'b0}};
    ptr_ext_s[IW-1:0]   = ptr;
    pick_s              = rr_pick(mask_ext_s, ptr_ext_s, (MAX_IW+1)'(BS));
    found               = pick_s[MAX_IW];
    idx                 = pick_s[IW-1:0];
    grant               = {BS{1'b0}};
    if (pick_s[MAX_IW]) begin
      grant[pick_s[IW-1:0]] = 1'b1;
    end else begin
      grant = {BS{1'b0}};
    end
  end

  assign unused_s = ^pick_s;

endmodule

// File: rtl/issue_scheduler.sv
// Slot allocator and round-robin issue arbiter for the instruction buffer.
// Optional feature: define ISSUE_SCHED_STALL_CNT_EN to add the stall_cnt output.
module issue_scheduler
  import issue_sched_pkg::*;
#(
  parameter int BS = 16,
  localparam int IW = $clog2(BS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [0:BS-1] independent_instr,
  input  logic          alloc_valid,
  output logic          alloc_ready,
  output logic [IW-1:0] alloc_index,
  output logic          issue_valid,
  input  logic          issue_ready,
  output logic [IW-1:0] issue_index,
  input  logic          complete_valid,
  input  logic [IW-1:0] complete_index,
  output logic          protocol_err
`ifdef ISSUE_SCHED_STALL_CNT_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);

  slot_state_t   state_r    [BS];
  slot_state_t   state_nx_s [BS];
  logic [IW-1:0] rr_ptr_r;
  logic [BS-1:0] free_mask_s;
  logic [BS-1:0] cand_mask_s;
  logic [BS-1:0] free_grant_s;
  logic [BS-1:0] pick_grant_s;
  logic          pick_found_s;
  logic [IW-1:0] pick_idx_s;
  logic          load_s;
  logic          accept_s;
  logic          alloc_fire_s;
  logic          cmpl_ok_s;
  logic          unused_s;

  // Per-slot masks from the registered state only
  always_comb begin
    for (int j = 0; j < BS; j++) begin
      free_mask_s[j] = (state_r[j] == FREE);
      cand_mask_s[j] = (state_r[j] == WAIT) & independent_instr[j];
    end
  end

  rr_arbiter #(.BS(BS)) u_free_pick (
    .mask  (free_mask_s),
    .ptr   ({IW{1'b0}}),
    .grant (free_grant_s),
    .found (alloc_ready),
    .idx   (alloc_index)
  );

  rr_arbiter #(.BS(BS)) u_issue_pick (
    .mask  (cand_mask_s),
    .ptr   (rr_ptr_r),
    .grant (pick_grant_s),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  assign unused_s     = ^free_grant_s;
  assign load_s       = ~issue_valid | issue_ready;
  assign accept_s     = issue_valid & issue_ready;
  assign alloc_fire_s = alloc_valid & alloc_ready;
  assign cmpl_ok_s    = complete_valid & (state_r[complete_index] == ISSUED);

  // Each event needs a distinct prior state, so at most one applies per slot
  always_comb begin
    for (int j = 0; j < BS; j++) begin
      state_nx_s[j] = state_r[j];
      if (accept_s && (issue_index == IW'(j))) begin
        state_nx_s[j] = ISSUED;
      end else if (cmpl_ok_s && (complete_index == IW'(j))) begin
        state_nx_s[j] = FREE;
      end else if (alloc_fire_s && (alloc_index == IW'(j))) begin
        state_nx_s[j] = WAIT;
      end else if (load_s && pick_grant_s[j]) begin
        state_nx_s[j] = SEL;
      end else begin
        state_nx_s[j] = state_r[j];
      end
    end
  end

  // Slot states, issue output register, round-robin pointer and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < BS; j++) begin
        state_r[j] <= FREE;
      end
      rr_ptr_r     <= {IW{1'b0}};
      issue_valid  <= 1'b0;
      issue_index  <= {IW{1'b0}};
      protocol_err <= 1'b0;
    end else begin
      for (int j = 0; j < BS; j++) begin
        state_r[j] <= state_nx_s[j];
      end
      if (load_s) begin
        issue_valid <= pick_found_s;
        if (pick_found_s) begin
          issue_index <= pick_idx_s;
          rr_ptr_r    <= pick_idx_s + IW'(1);
        end
      end
      if (complete_valid && !cmpl_ok_s) begin
        protocol_err <= 1'b1;
      end
    end
  end

`ifdef ISSUE_SCHED_STALL_CNT_EN
  // Saturating count of cycles an offered issue is held back by execute
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
    end else if (issue_valid && !issue_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  // Stall counter not present in this build.
`endif

endmodule
